wb_modport: RTL and testbench
=============================

WB_MODPORT -- requirements
Module: wb_modport

Interface
REQ-001 SHALL have parameter INSTANCES, default 2, number of downstream slaves.
REQ-002 SHALL have parameter BASE_ADDRESS[INSTANCES], default {0, 1024}, per-slave base address.
REQ-003 SHALL have parameter MEMORY_SPACE[INSTANCES], default {256, 256}, per-slave window size in address units.
REQ-004 SHALL have parameters DATA_WIDTH (32), ADDR_WIDTH (32) and TIMEOUT (16, cycles without ack before error).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 s_adr  input  ADDR_WIDTH  upstream address.
REQ-008 s_dat_i  input  DATA_WIDTH  upstream write data.
REQ-009 s_we / s_stb / s_cyc  input  1 each  upstream write enable, strobe, cycle.
REQ-010 s_dat_o  output  DATA_WIDTH  read data to upstream.
REQ-011 s_ack / s_err  output  1 each  upstream acknowledge, error.
REQ-012 m_adr  output  INSTANCES*ADDR_WIDTH  per-slave local address; slave j in slice j.
REQ-013 m_dat_i  output  INSTANCES*DATA_WIDTH  per-slave write data.
REQ-014 m_we / m_stb / m_cyc  output  INSTANCES each  per-slave control.
REQ-015 m_dat_o  input  INSTANCES*DATA_WIDTH  per-slave read data.
REQ-016 m_ack  input  INSTANCES  per-slave acknowledge.

Function
REQ-017 Elaboration SHALL abort with an error if any two windows overlap, any MEMORY_SPACE is not a power of two, or any BASE_ADDRESS is not a multiple of its MEMORY_SPACE.
REQ-018 With W_j = log2(MEMORY_SPACE[j]), hit_j SHALL be s_adr[ADDR_WIDTH-1:W_j] == BASE_ADDRESS[j][ADDR_WIDTH-1:W_j]; at most one hit_j is true.
REQ-019 m_adr slice j SHALL be s_adr[W_j-1:0] zero-extended to ADDR_WIDTH; m_dat_i and m_we SHALL broadcast s_dat_i and s_we to all slaves.
REQ-020 m_stb[j] SHALL be s_stb & hit_j; m_cyc[j] SHALL be s_cyc & hit_j; both combinational, zero latency.
REQ-021 s_dat_o and s_ack SHALL combinationally select m_dat_o/m_ack of the hit slave; with no hit, s_dat_o = 0 and s_ack = 0.
REQ-022 Unmapped access: when s_cyc & s_stb and no hit, s_err SHALL assert one cycle later for exactly one cycle; the following cycle s_err SHALL be 0 even if the strobe is still held.
REQ-023 Timeout: a counter SHALL increment each cycle with s_cyc & s_stb & a hit & no ack; it SHALL clear on ack, on s_stb or s_cyc low, or on address change to another slave.
REQ-024 When the counter reaches TIMEOUT, s_err SHALL pulse for one cycle, the counter SHALL clear, and m_stb/m_cyc of that slave SHALL be forced to 0 during the error cycle.
REQ-025 s_ack and s_err SHALL never be 1 in the same cycle; a slave ack arriving in the timeout error cycle SHALL be suppressed.

Reset
REQ-026 While rst_n = 0 at a clock edge: timeout counter = 0, s_err = 0, error-pulse state cleared; combinational outputs continue to follow inputs.
REQ-027 Reset asserted mid-transaction SHALL cancel any pending error; first evaluation after release starts the count from 0.

Structure
REQ-028 A shared package SHALL hold the default widths, the TIMEOUT default and the address-window check function used in elaboration.
REQ-029 One sub-module wb_modport_watchdog (timeout counter plus error pulse generator) SHALL be instantiated; decode and muxing stay in the top.

Verification
REQ-030 Read s_adr=0x10, slave0 m_dat_o=0xCAFEF00D, ack -> m_stb=01, m_adr[0]=0x10, s_dat_o=0xCAFEF00D, s_ack=1 same cycle.
REQ-031 Write s_adr=0x405, s_dat_i=0x12345678 -> m_stb=10, m_adr[1]=0x05, m_we[1]=1, m_dat_i[1]=0x12345678.
REQ-032 Access s_adr=0x200 (unmapped), held 3 cycles -> m_stb=00, s_ack=0, s_err=1 only in the cycle after strobe.
REQ-033 Access s_adr=0x0, slave0 never acks -> s_err=1 exactly at cycle 16, m_stb[0]=0 that cycle.
REQ-034 rst_n=0 during cycle 10 of a stalled access -> no s_err; after release, error at 16 cycles from restart.
REQ-035 Parameters BASE={0,128}, MEMORY_SPACE={256,256} -> elaboration fails with an overlap error.

Source files
------------

// File: rtl/wb_modport_pkg.sv
// Shared defaults and address-window helpers for the wb_modport interconnect.
// The helper functions are evaluated at elaboration to reject illegal slave maps.
package wb_modport_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_TIMEOUT    = 16;

  function automatic bit is_pow2(input int unsigned v);
    longint unsigned x;
    x = 64'(v);
    return (x != 64'd0) && ((x & (x - 64'd1)) == 64'd0);
  endfunction

  function automatic bit is_aligned(input int unsigned base, input int unsigned size);
    return (size != 0) && ((base % size) == 0);
  endfunction

  // Window check: a legal window has a power-of-two size and a naturally aligned base.
  function automatic bit window_ok(input int unsigned base, input int unsigned size);
    return is_pow2(size) && is_aligned(base, size);
  endfunction

  // 64-bit math keeps windows near the top of the address space from wrapping.
  function automatic bit windows_overlap(input int unsigned base_a, input int unsigned size_a,
                                         input int unsigned base_b, input int unsigned size_b);
    longint unsigned a0, a1, b0, b1;
    a0 = 64'(base_a);
    a1 = a0 + 64'(size_a);
    b0 = 64'(base_b);
    b1 = b0 + 64'(size_b);
    return (a0 < b1) && (b0 < a1);
  endfunction

endpackage

// File: rtl/wb_modport_watchdog.sv
// Stall timeout counter plus one-cycle error pulse generator.
// Flags unmapped accesses once per access and hit accesses that go TIMEOUT cycles without ack.
module wb_modport_watchdog
  import wb_modport_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned SEL_W   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             hit,
  input  logic             ack,
  input  logic [SEL_W-1:0] sel,
  output logic             err,
  output logic             tout,
  output logic [SEL_W-1:0] tout_sel
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [SEL_W-1:0] sel_q;
  logic             unmapped_seen;
  logic             stall;
  logic             unmapped;

  // The slave is not strobed during its own timeout cycle, so that cycle does not count.
  assign stall    = req & hit & ~ack & ~tout;
  assign unmapped = req & ~hit;
  assign cnt_next = ((cnt != '0) && (sel == sel_q)) ? cnt + 1'b1 : CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      sel_q         <= '0;
      unmapped_seen <= 1'b0;
      err           <= 1'b0;
      tout          <= 1'b0;
      tout_sel      <= '0;
    end else begin
      err           <= 1'b0;
      tout          <= 1'b0;
      unmapped_seen <= unmapped;
      if (unmapped && !unmapped_seen) err <= 1'b1;
      if (stall) begin
        sel_q <= sel;
        if (cnt_next == CNT_W'(TIMEOUT)) begin
          cnt      <= '0;
          err      <= 1'b1;
          tout     <= 1'b1;
          tout_sel <= sel;
        end else begin
          cnt <= cnt_next;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/wb_modport.sv
// One-master, N-slave Wishbone address decoder with read mux and bus watchdog.
// Decode and muxing are purely combinational; only the error path is registered.
module wb_modport
  import wb_modport_pkg::*;
#(
  parameter int unsigned INSTANCES                   = 2,
  parameter int unsigned BASE_ADDRESS [INSTANCES]    = '{32'd0, 32'd1024},
  parameter int unsigned MEMORY_SPACE [INSTANCES]    = '{32'd256, 32'd256},
  parameter int unsigned DATA_WIDTH                  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH                  = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT                     = DEF_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ADDR_WIDTH-1:0]           s_adr,
  input  logic [DATA_WIDTH-1:0]           s_dat_i,
  input  logic                            s_we,
  input  logic                            s_stb,
  input  logic                            s_cyc,
  output logic [DATA_WIDTH-1:0]           s_dat_o,
  output logic                            s_ack,
  output logic                            s_err,
  output logic [INSTANCES*ADDR_WIDTH-1:0] m_adr,
  output logic [INSTANCES*DATA_WIDTH-1:0] m_dat_i,
  output logic [INSTANCES-1:0]            m_we,
  output logic [INSTANCES-1:0]            m_stb,
  output logic [INSTANCES-1:0]            m_cyc,
  input  logic [INSTANCES*DATA_WIDTH-1:0] m_dat_o,
  input  logic [INSTANCES-1:0]            m_ack
);

  localparam int unsigned SEL_W = (INSTANCES > 1) ? $clog2(INSTANCES) : 1;

  logic [INSTANCES-1:0]  hit;
  logic [INSTANCES-1:0]  blocked;
  logic [SEL_W-1:0]      sel;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  sel_ack;
  logic                  tout;
  logic [SEL_W-1:0]      tout_sel;

  for (genvar j = 0; j < INSTANCES; j++) begin : g_slave
    if (!window_ok(BASE_ADDRESS[j], MEMORY_SPACE[j]))
      $error("wb_modport: slave %0d window base=0x%0h size=0x%0h is not a power of two or not aligned",
             j, BASE_ADDRESS[j], MEMORY_SPACE[j]);
    for (genvar k = j + 1; k < INSTANCES; k++) begin : g_ovl
      if (windows_overlap(BASE_ADDRESS[j], MEMORY_SPACE[j], BASE_ADDRESS[k], MEMORY_SPACE[k]))
        $error("wb_modport: windows of slave %0d and slave %0d overlap", j, k);
    end

    localparam int unsigned           W    = $clog2(MEMORY_SPACE[j]);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDRESS[j]);
    localparam logic [ADDR_WIDTH-1:0] MASK = ADDR_WIDTH'(MEMORY_SPACE[j] - 1);

    assign hit[j]     = (s_adr >> W) == (BASE >> W);
    assign blocked[j] = tout & (tout_sel == SEL_W'(j));
    assign m_adr[j*ADDR_WIDTH +: ADDR_WIDTH] = s_adr & MASK;
    assign m_stb[j]   = s_stb & hit[j] & ~blocked[j];
    assign m_cyc[j]   = s_cyc & hit[j] & ~blocked[j];
  end

  assign m_we    = {INSTANCES{s_we}};
  assign m_dat_i = {INSTANCES{s_dat_i}};

  always_comb begin
    sel     = '0;
    sel_dat = '0;
    sel_ack = 1'b0;
    for (int j = 0; j < INSTANCES; j++) begin
      if (hit[j]) begin
        sel     = SEL_W'(j);
        sel_dat = m_dat_o[j*DATA_WIDTH +: DATA_WIDTH];
        sel_ack = m_ack[j];
      end
    end
  end

  assign s_dat_o = sel_dat;
  // An ack that lands in an error cycle is dropped so ack and err stay exclusive.
  assign s_ack   = sel_ack & ~s_err;

  wb_modport_watchdog #(
    .TIMEOUT (TIMEOUT),
    .SEL_W   (SEL_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (s_cyc & s_stb),
    .hit      (|hit),
    .ack      (sel_ack),
    .sel      (sel),
    .err      (s_err),
    .tout     (tout),
    .tout_sel (tout_sel)
  );

endmodule

// File: tb/tb_wb_modport.sv
// Directed bench for wb_modport: a table of combinational decode vectors
// followed by hand-written unmapped, timeout and reset-during-stall sequences.
module tb_wb_modport;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_adr, s_dat_i, s_dat_o;
  logic        s_we, s_stb, s_cyc, s_ack, s_err;
  logic [63:0] m_adr, m_dat_i, m_dat_o;
  logic [1:0]  m_we, m_stb, m_cyc, m_ack;

  int total = 0;
  int bad   = 0;

  wb_modport dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_adr   (s_adr),
    .s_dat_i (s_dat_i),
    .s_we    (s_we),
    .s_stb   (s_stb),
    .s_cyc   (s_cyc),
    .s_dat_o (s_dat_o),
    .s_ack   (s_ack),
    .s_err   (s_err),
    .m_adr   (m_adr),
    .m_dat_i (m_dat_i),
    .m_we    (m_we),
    .m_stb   (m_stb),
    .m_cyc   (m_cyc),
    .m_dat_o (m_dat_o),
    .m_ack   (m_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [63:0] mdo;
    logic [1:0]  mack;
    logic [1:0]  e_stb;
    logic [1:0]  e_cyc;
    logic [63:0] e_madr;
    logic [31:0] e_sdo;
    logic        e_ack;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    s_adr   = 32'h0;
    s_dat_i = 32'h0;
    s_we    = 1'b0;
    s_stb   = 1'b0;
    s_cyc   = 1'b0;
    m_dat_o = 64'h0;
    m_ack   = 2'b00;
  endtask

  initial begin
    //            adr           dat           we    stb   cyc   mdo {s1,s0}                    mack   e_stb  e_cyc  e_madr {s1,s0}            e_sdo         e_ack
    vecs[0] = '{32'h00000010, 32'h00000000, 1'b0, 1'b1, 1'b1, {32'h11111111, 32'hCAFEF00D}, 2'b01, 2'b01, 2'b01, {32'h10, 32'h10}, 32'hCAFEF00D, 1'b1};
    vecs[1] = '{32'h00000405, 32'h12345678, 1'b1, 1'b1, 1'b1, {32'hBEEF0001, 32'hCAFEF00D}, 2'b10, 2'b10, 2'b10, {32'h05, 32'h05}, 32'hBEEF0001, 1'b1};
    vecs[2] = '{32'h00000200, 32'h00000000, 1'b0, 1'b1, 1'b1, {32'h22222222, 32'h33333333}, 2'b11, 2'b00, 2'b00, {32'h00, 32'h00}, 32'h00000000, 1'b0};
    vecs[3] = '{32'h000004FF, 32'h00000000, 1'b0, 1'b1, 1'b0, {32'h44444444, 32'h55555555}, 2'b10, 2'b10, 2'b00, {32'hFF, 32'hFF}, 32'h44444444, 1'b1};
    vecs[4] = '{32'h000000FF, 32'h0000AABB, 1'b1, 1'b0, 1'b1, {32'h66666666, 32'h77777777}, 2'b00, 2'b00, 2'b01, {32'hFF, 32'hFF}, 32'h77777777, 1'b0};
    vecs[5] = '{32'h00000500, 32'h00000000, 1'b0, 1'b0, 1'b0, {32'h88888888, 32'h99999999}, 2'b11, 2'b00, 2'b00, {32'h00, 32'h00}, 32'h00000000, 1'b0};
    vecs[6] = '{32'h00000100, 32'h00000000, 1'b0, 1'b1, 1'b1, {32'hAAAAAAAA, 32'hBBBBBBBB}, 2'b11, 2'b00, 2'b00, {32'h00, 32'h00}, 32'h00000000, 1'b0};
    vecs[7] = '{32'hFFFF0410, 32'h00000000, 1'b0, 1'b1, 1'b1, {32'hCCCCCCCC, 32'hDDDDDDDD}, 2'b10, 2'b00, 2'b00, {32'h10, 32'h10}, 32'h00000000, 1'b0};
    vecs[8] = '{32'h00000401, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b1, {32'h00000009, 32'hEEEEEEEE}, 2'b00, 2'b10, 2'b10, {32'h01, 32'h01}, 32'h00000009, 1'b0};

    // Reset: registered error clear, combinational path still live.
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_err", 64'(s_err), 64'd0);
    s_adr = 32'h10; s_stb = 1'b1; s_cyc = 1'b1; m_ack = 2'b01; m_dat_o = {32'h0, 32'h0000ABCD};
    #1;
    chk("reset_comb_ack", 64'(s_ack), 64'd1);
    chk("reset_comb_dat", 64'(s_dat_o), 64'h0000ABCD);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      s_adr   = vecs[i].adr;
      s_dat_i = vecs[i].dat;
      s_we    = vecs[i].we;
      s_stb   = vecs[i].stb;
      s_cyc   = vecs[i].cyc;
      m_dat_o = vecs[i].mdo;
      m_ack   = vecs[i].mack;
      #1;
      chk($sformatf("v%0d_m_stb", i), 64'(m_stb), 64'(vecs[i].e_stb));
      chk($sformatf("v%0d_m_cyc", i), 64'(m_cyc), 64'(vecs[i].e_cyc));
      chk($sformatf("v%0d_m_adr", i), m_adr, vecs[i].e_madr);
      chk($sformatf("v%0d_s_dat_o", i), 64'(s_dat_o), 64'(vecs[i].e_sdo));
      chk($sformatf("v%0d_s_ack", i), 64'(s_ack), 64'(vecs[i].e_ack));
      chk($sformatf("v%0d_m_we", i), 64'(m_we), {62'd0, vecs[i].we, vecs[i].we});
      chk($sformatf("v%0d_m_dat_i", i), m_dat_i, {vecs[i].dat, vecs[i].dat});
      chk($sformatf("v%0d_s_err", i), 64'(s_err), 64'd0);
      @(negedge clk);
      drive_idle();
      repeat (3) @(negedge clk);
    end

    // Unmapped access held three cycles: one error pulse, in the cycle after the strobe.
    s_adr = 32'h200; s_stb = 1'b1; s_cyc = 1'b1; m_ack = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) #1;
      else begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("unmapped_err_c%0d", k), 64'(s_err), (k == 1) ? 64'd1 : 64'd0);
      chk($sformatf("unmapped_ack_c%0d", k), 64'(s_ack), 64'd0);
      chk($sformatf("unmapped_stb_c%0d", k), 64'(m_stb), 64'd0);
    end
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);

    // Stalled slave 0: error in cycle 16 and again in cycle 33 while the strobe is held.
    s_adr = 32'h0; s_stb = 1'b1; s_cyc = 1'b1;
    for (int k = 0; k < 35; k++) begin
      if (k == 0) #1;
      else begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("tout_err_c%0d", k), 64'(s_err), (k == 16 || k == 33) ? 64'd1 : 64'd0);
      chk($sformatf("tout_stb_c%0d", k), 64'(m_stb), (k == 16 || k == 33) ? 64'd0 : 64'd1);
      if (k == 16) begin
        m_ack = 2'b01;
        #1;
        chk("tout_ack_suppressed", 64'(s_ack), 64'd0);
        chk("tout_cyc_forced", 64'(m_cyc), 64'd0);
        m_ack = 2'b00;
      end
    end
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);

    // Reset during cycle 10 of a stall: no error, then a fresh 16-cycle count from cycle 11.
    s_adr = 32'h404; s_stb = 1'b1; s_cyc = 1'b1;
    for (int k = 0; k < 29; k++) begin
      if (k == 0) #1;
      else begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("rst_err_c%0d", k), 64'(s_err), (k == 27) ? 64'd1 : 64'd0);
      if (k == 10) rst_n = 1'b0;
      if (k == 11) rst_n = 1'b1;
    end
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
